bcd_time_counter: RTL and testbench

BCD_TIME_COUNTER -- requirements
Module: bcd_time_counter

---
 rtl/bcd_time_counter.sv | 222 ++++++++++++++++++++++
 tb/tb_bcd_time_counter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_time_counter.sv
// HH:MM:SS BCD timekeeper with prescaler, field loads and day wrap.
// Optional alarm compiled in with `define BCD_TIME_ALARM_EN.
module bcd_time_counter #(
  parameter int CLK_DIV = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run,
  input  logic       set_en,
  input  logic [1:0] set_sel,
  input  logic [7:0] set_val,
`ifdef BCD_TIME_ALARM_EN
  input  logic        alarm_set,
  input  logic [15:0] alarm_val,
  input  logic        alarm_on,
  input  logic        alarm_ack,
  output logic        alarm_hit,
`endif
  output logic [3:0] h_tens,
  output logic [3:0] h_ones,
  output logic [3:0] m_tens,
  output logic [3:0] m_ones,
  output logic [3:0] s_tens,
  output logic [3:0] s_ones,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       set_err
);

  localparam int PW =
    (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [PW-1:0] PTOP =
    PW'(CLK_DIV - 1);

  logic [PW-1:0] presc;
  logic          term;
  logic          adv;

  logic [3:0] v_t;
  logic [3:0] v_o;
  logic       ld_ok;
  logic       ld_sec;

  logic       cs;
  logic       cst;
  logic       cm;
  logic       cmt;
  logic       h23;
  logic       wrap;

  logic [3:0] n_ht;
  logic [3:0] n_ho;
  logic [3:0] n_mt;
  logic [3:0] n_mo;
  logic [3:0] n_st;
  logic [3:0] n_so;

  logic       alm_err;

  // A load in the terminal cycle swallows
  // that cycle's advance entirely.
  assign term = run & (presc == PTOP);
  assign adv  = term & ~set_en;

  assign v_t = set_val[7:4];
  assign v_o = set_val[3:0];

  // Range check of the load value for the
  // selected field.
  always_comb begin
    ld_ok = 1'b0;
    unique case (set_sel)
      2'd0: ld_ok = (v_t <= 4'd5)
                  & (v_o <= 4'd9);
      2'd1: ld_ok = (v_t <= 4'd5)
                  & (v_o <= 4'd9);
      2'd2: ld_ok = (set_val <= 8'h23)
                  & (v_o <= 4'd9);
      2'd3: ld_ok = 1'b0;
    endcase
  end

  assign ld_sec = set_en & ld_ok
                & (set_sel == 2'd0);

  assign cs  = (s_ones == 4'd9);
  assign cst = cs & (s_tens == 4'd5);
  assign cm  = cst & (m_ones == 4'd9);
  assign cmt = cm & (m_tens == 4'd5);
  assign h23 = (h_tens == 4'd2)
             & (h_ones == 4'd3);
  assign wrap = cmt & h23;

  // Time one second ahead of the current
  // digits, with the BCD carry chain.
  always_comb begin
    n_so = cs ? 4'd0 : s_ones + 4'd1;
    n_st = s_tens;
    n_mo = m_ones;
    n_mt = m_tens;
    n_ho = h_ones;
    n_ht = h_tens;
    if (cs)
      n_st = cst ? 4'd0 : s_tens + 4'd1;
    if (cst)
      n_mo = cm ? 4'd0 : m_ones + 4'd1;
    if (cm)
      n_mt = cmt ? 4'd0 : m_tens + 4'd1;
    if (cmt) begin
      if (h23) begin
        n_ht = 4'd0;
        n_ho = 4'd0;
      end else if (h_ones == 4'd9) begin
        n_ht = h_tens + 4'd1;
        n_ho = 4'd0;
      end else begin
        n_ho = h_ones + 4'd1;
      end
    end
  end

  // Prescaler: free-runs under run, cleared
  // by a valid seconds load.
  always_ff @(posedge clk) begin
    if (rst)
      presc <= '0;
    else if (ld_sec)
      presc <= '0;
    else if (run)
      presc <= term ? '0 : presc + 1'b1;
  end

  // Time digits: load beats advance.
  always_ff @(posedge clk) begin
    if (rst) begin
      h_tens <= 4'd0;
      h_ones <= 4'd0;
      m_tens <= 4'd0;
      m_ones <= 4'd0;
      s_tens <= 4'd0;
      s_ones <= 4'd0;
    end else if (set_en) begin
      if (ld_ok) begin
        unique case (set_sel)
          2'd0: begin
            s_tens <= v_t;
            s_ones <= v_o;
          end
          2'd1: begin
            m_tens <= v_t;
            m_ones <= v_o;
          end
          2'd2: begin
            h_tens <= v_t;
            h_ones <= v_o;
          end
          2'd3: ;
        endcase
      end
    end else if (adv) begin
      h_tens <= n_ht;
      h_ones <= n_ho;
      m_tens <= n_mt;
      m_ones <= n_mo;
      s_tens <= n_st;
      s_ones <= n_so;
    end
  end

  // Registered one-cycle status pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_tick <= 1'b0;
      day_wrap <= 1'b0;
      set_err  <= 1'b0;
    end else begin
      sec_tick <= adv;
      day_wrap <= adv & wrap;
      set_err  <= (set_en & ~ld_ok)
                | alm_err;
    end
  end

`ifdef BCD_TIME_ALARM_EN
  logic [15:0] alm;
  logic        alm_ok;
  logic        hit_new;

  assign alm_ok =
    (alarm_val[15:8] <= 8'h23)
    & (alarm_val[11:8] <= 4'd9)
    & (alarm_val[7:4] <= 4'd5)
    & (alarm_val[3:0] <= 4'd9);

  assign alm_err = alarm_set & ~alm_ok;

  assign hit_new = adv & alarm_on
    & (n_st == 4'd0) & (n_so == 4'd0)
    & ({n_ht, n_ho, n_mt, n_mo} == alm);

  // Alarm register and sticky hit flag;
  // a fresh hit wins over acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      alm       <= 16'h0000;
      alarm_hit <= 1'b0;
    end else begin
      if (alarm_set & alm_ok)
        alm <= alarm_val;
      if (!alarm_on)
        alarm_hit <= 1'b0;
      else if (hit_new)
        alarm_hit <= 1'b1;
      else if (alarm_ack)
        alarm_hit <= 1'b0;
    end
  end
`else
  assign alm_err = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed bench for bcd_time_counter
// with CLK_DIV = 4.
module tb_bcd_time_counter;

  logic       clk = 1'b0;
  logic       rst;
  logic       run;
  logic       set_en;
  logic [1:0] set_sel;
  logic [7:0] set_val;
  logic [3:0] h_tens, h_ones;
  logic [3:0] m_tens, m_ones;
  logic [3:0] s_tens, s_ones;
  logic       sec_tick;
  logic       day_wrap;
  logic       set_err;
`ifdef BCD_TIME_ALARM_EN
  logic        alarm_set = 1'b0;
  logic [15:0] alarm_val = 16'h0;
  logic        alarm_on  = 1'b0;
  logic        alarm_ack = 1'b0;
  logic        alarm_hit;
`endif

  int npass = 0;
  int ntot  = 0;

  always #5 clk = ~clk;

  bcd_time_counter #(.CLK_DIV(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .set_en   (set_en),
    .set_sel  (set_sel),
    .set_val  (set_val),
`ifdef BCD_TIME_ALARM_EN
    .alarm_set(alarm_set),
    .alarm_val(alarm_val),
    .alarm_on (alarm_on),
    .alarm_ack(alarm_ack),
    .alarm_hit(alarm_hit),
`endif
    .h_tens   (h_tens),
    .h_ones   (h_ones),
    .m_tens   (m_tens),
    .m_ones   (m_ones),
    .s_tens   (s_tens),
    .s_ones   (s_ones),
    .sec_tick (sec_tick),
    .day_wrap (day_wrap),
    .set_err  (set_err)
  );

  typedef struct {
    logic        rst;
    logic        run;
    logic        se;
    logic [1:0]  sel;
    logic [7:0]  val;
    logic [23:0] t;
    logic        tk;
    logic        dw;
    logic        er;
  } vec_t;

  vec_t vq[$];

  task automatic add(
    input logic rst_i, input logic run_i,
    input logic se_i, input logic [1:0] sel_i,
    input logic [7:0] val_i,
    input logic [23:0] t_i, input logic tk_i,
    input logic dw_i, input logic er_i);
    vec_t v;
    v.rst = rst_i; v.run = run_i;
    v.se = se_i; v.sel = sel_i; v.val = val_i;
    v.t = t_i; v.tk = tk_i;
    v.dw = dw_i; v.er = er_i;
    vq.push_back(v);
  endtask

  task automatic cyc(
    input logic r, input logic rn,
    input logic se, input logic [1:0] sl,
    input logic [7:0] vl);
    rst = r; run = rn; set_en = se;
    set_sel = sl; set_val = vl;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm,
    input logic [23:0] t, input logic tk,
    input logic dw, input logic er);
    logic [26:0] got, exp;
    got = {h_tens, h_ones, m_tens, m_ones,
           s_tens, s_ones,
           sec_tick, day_wrap, set_err};
    exp = {t, tk, dw, er};
    ntot++;
    if (got === exp)
      npass++;
    else
      $display("FAIL %s: got t=%h tk/dw/er=%b req t=%h tk/dw/er=%b",
               nm, got[26:3], got[2:0],
               exp[26:3], exp[2:0]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; run = 1'b0; set_en = 1'b0;
    set_sel = 2'd0; set_val = 8'h00;

    // reset and plain counting
    add(1,0,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,0,0,8'h00, 24'h000001,1,0,0);
    add(0,1,0,0,8'h00, 24'h000001,0,0,0);
    add(0,1,0,0,8'h00, 24'h000001,0,0,0);
    add(0,1,0,0,8'h00, 24'h000001,0,0,0);
    add(0,1,0,0,8'h00, 24'h000002,1,0,0);
    // rejected loads
    add(0,0,1,1,8'h60, 24'h000002,0,0,1);
    add(0,0,0,0,8'h00, 24'h000002,0,0,0);
    add(0,0,1,2,8'h24, 24'h000002,0,0,1);
    add(0,0,1,3,8'h00, 24'h000002,0,0,1);
    add(0,0,1,0,8'h5A, 24'h000002,0,0,1);
    add(0,0,0,0,8'h00, 24'h000002,0,0,0);
    // 23:59:59 -> day wrap
    add(0,0,1,2,8'h23, 24'h230002,0,0,0);
    add(0,0,1,1,8'h59, 24'h235902,0,0,0);
    add(0,0,1,0,8'h59, 24'h235959,0,0,0);
    add(0,1,0,0,8'h00, 24'h235959,0,0,0);
    add(0,1,0,0,8'h00, 24'h235959,0,0,0);
    add(0,1,0,0,8'h00, 24'h235959,0,0,0);
    add(0,1,0,0,8'h00, 24'h000000,1,1,0);
    // seconds load on terminal count
    add(0,1,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,0,0,8'h00, 24'h000000,0,0,0);
    add(0,1,1,0,8'h30, 24'h000030,0,0,0);
    add(0,1,0,0,8'h00, 24'h000030,0,0,0);
    add(0,1,0,0,8'h00, 24'h000030,0,0,0);
    add(0,1,0,0,8'h00, 24'h000030,0,0,0);
    add(0,1,0,0,8'h00, 24'h000031,1,0,0);
    // invalid load on terminal count
    add(0,1,0,0,8'h00, 24'h000031,0,0,0);
    add(0,1,0,0,8'h00, 24'h000031,0,0,0);
    add(0,1,0,0,8'h00, 24'h000031,0,0,0);
    add(0,1,1,1,8'h7A, 24'h000031,0,0,1);
    add(0,1,0,0,8'h00, 24'h000031,0,0,0);
    add(0,1,0,0,8'h00, 24'h000031,0,0,0);
    add(0,1,0,0,8'h00, 24'h000031,0,0,0);
    add(0,1,0,0,8'h00, 24'h000032,1,0,0);
    // minute load keeps prescaler phase
    add(0,1,1,1,8'h45, 24'h004532,0,0,0);
    add(0,1,0,0,8'h00, 24'h004532,0,0,0);
    add(0,1,0,0,8'h00, 24'h004532,0,0,0);
    add(0,1,0,0,8'h00, 24'h004533,1,0,0);
    // 09:59:59 -> 10:00:00
    add(0,0,1,2,8'h09, 24'h094533,0,0,0);
    add(0,0,1,1,8'h59, 24'h095933,0,0,0);
    add(0,0,1,0,8'h59, 24'h095959,0,0,0);
    add(0,1,0,0,8'h00, 24'h095959,0,0,0);
    add(0,1,0,0,8'h00, 24'h095959,0,0,0);
    add(0,1,0,0,8'h00, 24'h095959,0,0,0);
    add(0,1,0,0,8'h00, 24'h100000,1,0,0);
    // reset mid-second at 12:34:56
    add(0,0,1,2,8'h12, 24'h120000,0,0,0);
    add(0,0,1,1,8'h34, 24'h123400,0,0,0);
    add(0,0,1,0,8'h56, 24'h123456,0,0,0);
    add(0,1,0,0,8'h00, 24'h123456,0,0,0);
    add(0,1,0,0,8'h00, 24'h123456,0,0,0);
    add(1,1,1,1,8'h99, 24'h000000,0,0,0);

    foreach (vq[i]) begin
      cyc(vq[i].rst, vq[i].run, vq[i].se,
          vq[i].sel, vq[i].val);
      chk($sformatf("vec%0d", i), vq[i].t,
          vq[i].tk, vq[i].dw, vq[i].er);
    end

    // frozen for 20 cycles
    for (int i = 0; i < 20; i++) begin
      cyc(0,0,0,0,8'h00);
      chk($sformatf("hold%0d", i),
          24'h000000,0,0,0);
    end

    // first advance CLK_DIV cycles in
    for (int i = 0; i < 4; i++) begin
      cyc(0,1,0,0,8'h00);
      chk($sformatf("rel%0d", i),
          (i == 3) ? 24'h000001 : 24'h000000,
          (i == 3), 0, 0);
    end

    // reset beats a pending advance
    for (int i = 0; i < 3; i++)
      cyc(0,1,0,0,8'h00);
    cyc(1,1,0,0,8'h00);
    chk("rst_term", 24'h000000,0,0,0);
    cyc(0,1,0,0,8'h00);
    chk("rst_term_p1", 24'h000000,0,0,0);

`ifdef BCD_TIME_ALARM_EN
    cyc(1,0,0,0,8'h00);
    alarm_on  = 1'b1;
    alarm_set = 1'b1;
    alarm_val = 16'h2400;
    cyc(0,0,0,0,8'h00);
    chk("alm_bad", 24'h000000,0,0,1);
    alarm_val = 16'h0001;
    cyc(0,0,0,0,8'h00);
    chk("alm_ok", 24'h000000,0,0,0);
    alarm_set = 1'b0;
    cyc(0,0,1,0,8'h59);
    for (int i = 0; i < 4; i++) begin
      cyc(0,1,0,0,8'h00);
      ntot++;
      if (alarm_hit === (i == 3))
        npass++;
      else
        $display("FAIL alm_run%0d: got %b req %b",
                 i, alarm_hit, (i == 3));
    end
    chk("alm_time", 24'h000100,1,0,0);
    cyc(0,0,0,0,8'h00);
    cyc(0,0,0,0,8'h00);
    ntot++;
    if (alarm_hit === 1'b1) npass++;
    else $display("FAIL alm_hold: got %b req 1",
                  alarm_hit);
    alarm_ack = 1'b1;
    cyc(0,0,0,0,8'h00);
    alarm_ack = 1'b0;
    ntot++;
    if (alarm_hit === 1'b0) npass++;
    else $display("FAIL alm_ack: got %b req 0",
                  alarm_hit);
`endif

    $display("%0d/%0d checks passed",
             npass, ntot);
    $finish;
  end

endmodule
